// File: rtl/perf_counter_bank_if.sv
// MEM-stage store port into the performance counter window.
// The master drives the store, and the slave returns the window hit and the acknowledge.
interface perf_counter_bank_if;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        wr_hit;
  logic        wr_resp;

  modport master (
    output mem_write,
    output mem_address,
    output mem_wdata,
    output mem_byte_enable,
    input  wr_hit,
    input  wr_resp
  );

  modport slave (
    input  mem_write,
    input  mem_address,
    input  mem_wdata,
    input  mem_byte_enable,
    output wr_hit,
    output wr_resp
  );
endinterface

// File: rtl/perf_counter_bank.sv
// Nine 32-bit event counters plus a CTRL word, all memory-mapped at BASE.
// Software stores to the window can preset, clear or freeze the counters.
module perf_counter_bank #(
  parameter logic [31:0] BASE  = 32'h0000_0000,
  parameter int          WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ev_branch,
  input  logic             ev_mispredict,
  input  logic             ev_icache_hit,
  input  logic             ev_icache_miss,
  input  logic             ev_dcache_hit,
  input  logic             ev_dcache_miss,
  input  logic             ev_l2_hit,
  input  logic             ev_l2_miss,
  input  logic             ev_stall,
  perf_counter_bank_if.slave bus,
  output logic [WIDTH-1:0] branch,
  output logic [WIDTH-1:0] mispredict,
  output logic [WIDTH-1:0] I_cache_hit,
  output logic [WIDTH-1:0] I_cache_miss,
  output logic [WIDTH-1:0] D_cache_hit,
  output logic [WIDTH-1:0] D_cache_miss,
  output logic [WIDTH-1:0] l2_cache_hit,
  output logic [WIDTH-1:0] l2_cache_miss,
  output logic [WIDTH-1:0] stall_counter,
  output logic             count_en
);

  localparam int          NUM_CNT    = 9;
  localparam logic [3:0]  CTRL_IDX   = 4'd9;
  localparam logic [31:0] LAST_OFFS  = 32'h0000_0024;

  logic [WIDTH-1:0] cnt_r     [NUM_CNT];
  logic [WIDTH-1:0] cnt_nxt_s [NUM_CNT];
  logic             count_en_r;
  logic             count_en_nxt_s;
  logic             wr_resp_r;
  logic [31:0]      offset_s;
  logic [3:0]       idx_s;
  logic             hit_s;
  logic             ctrl_wr_s;
  logic             clear_s;
  logic [NUM_CNT-1:0] ev_s;

  function automatic logic [WIDTH-1:0] merge_lanes(
    input logic [WIDTH-1:0] old_v,
    input logic [31:0]      new_v,
    input logic [3:0]       be
  );
    logic [WIDTH-1:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

  assign ev_s = {ev_stall, ev_l2_miss, ev_l2_hit, ev_dcache_miss, ev_dcache_hit,
                 ev_icache_miss, ev_icache_hit, ev_mispredict, ev_branch};

  // An address below BASE wraps to a large offset, so one unsigned compare bounds the window.
  assign offset_s  = bus.mem_address - BASE;
  assign hit_s     = bus.mem_write && (offset_s <= LAST_OFFS) && (offset_s[1:0] == 2'b00);
  assign idx_s     = offset_s[5:2];
  assign ctrl_wr_s = hit_s && (idx_s == CTRL_IDX) && bus.mem_byte_enable[0];
  assign clear_s   = ctrl_wr_s && bus.mem_wdata[1];

  // Next counter values: clear beats a store, and a store beats that cycle's event.
  always_comb begin
    count_en_nxt_s = count_en_r;
    if (ctrl_wr_s) begin
      count_en_nxt_s = bus.mem_wdata[0];
    end else begin
      count_en_nxt_s = count_en_r;
    end
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (clear_s) begin
        cnt_nxt_s[i] = {WIDTH{1'b0}};
      end else if (hit_s && (idx_s == 4'(i))) begin
        cnt_nxt_s[i] = merge_lanes(cnt_r[i], bus.mem_wdata, bus.mem_byte_enable);
      end else if (count_en_r && ev_s[i]) begin
        cnt_nxt_s[i] = cnt_r[i] + WIDTH'(1);
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
  end

  // State registers, with reset taking priority over events and stores.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_r[i] <= {WIDTH{1'b0}};
      end
      count_en_r <= 1'b1;
      wr_resp_r  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      count_en_r <= count_en_nxt_s;
      wr_resp_r  <= hit_s;
    end
  end

  assign bus.wr_hit  = hit_s;
  assign bus.wr_resp = wr_resp_r;

  assign branch        = cnt_r[0];
  assign mispredict    = cnt_r[1];
  assign I_cache_hit   = cnt_r[2];
  assign I_cache_miss  = cnt_r[3];
  assign D_cache_hit   = cnt_r[4];
  assign D_cache_miss  = cnt_r[5];
  assign l2_cache_hit  = cnt_r[6];
  assign l2_cache_miss = cnt_r[7];
  assign stall_counter = cnt_r[8];
  assign count_en      = count_en_r;

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Owns the processor's nine 32-bit performance counters.
- Increments each counter from pipeline and cache event strobes.
- Accepts MEM-stage stores to the counter address window, so software can clear, preset or freeze counters.
- Presents all counter values to the load-side read mux, with 0x00..0x20 offsets identical on both sides.

Parameters:
- BASE, 32'h0000_0000, byte address of counter window; offsets below are relative to BASE.
- WIDTH, 32, counter width in bits; fixed at 32 for this design.

Ports:
- clk  input  1  processor clock.
- rst  input  1  synchronous active-high reset.
- ev_branch  input  1  branch resolved this cycle.
- ev_mispredict  input  1  branch mispredicted this cycle.
- ev_icache_hit / ev_icache_miss  input  1 each  I-cache outcome strobes.
- ev_dcache_hit / ev_dcache_miss  input  1 each  D-cache outcome strobes.
- ev_l2_hit / ev_l2_miss  input  1 each  L2 outcome strobes.
- ev_stall  input  1  pipeline stalled this cycle.
- mem_write  input  1  MEM-stage store request.
- mem_address  input  32  store byte address.
- mem_wdata  input  32  store data.
- mem_byte_enable  input  4  store byte lanes.
- wr_hit  output  1  combinational: the current store targets the counter window (used to suppress the D-cache write).
- wr_resp  output  1  registered store acknowledge.
- branch, mispredict, I_cache_hit, I_cache_miss, D_cache_hit, D_cache_miss, l2_cache_hit, l2_cache_miss, stall_counter  output  32 each  counter values to the read mux.
- count_en  output  1  current global enable.

Behaviour:
- Register map (offset: register):
  - 0x00 branch
  - 0x04 mispredict
  - 0x08 I_cache_hit
  - 0x0C I_cache_miss
  - 0x10 D_cache_hit
  - 0x14 D_cache_miss
  - 0x18 l2_cache_hit
  - 0x1C l2_cache_miss
  - 0x20 stall_counter
  - 0x24 CTRL: bit0 = count_en, bit1 = clear_all (write-one, self-clearing, never stored).
- Address decode:
  - wr_hit = mem_write && mem_address is one of BASE+0x00..BASE+0x24 on a word boundary (address[1:0] == 0).
  - Any other address has no effect and wr_hit = 0.
- Reset (rst high at clk edge):
  - All counters = 0, count_en = 1, wr_resp = 0.
  - Reset overrides events and writes in the same cycle.
  - Reset mid-sequence discards any pending wr_resp.
- Counting:
  - Each cycle with count_en = 1 and its ev_* high, the matching counter += 1.
  - Events are level-counted: one increment per cycle asserted. ev_stall held for N cycles adds N.
  - Arithmetic is modulo 2^32: 32'hFFFF_FFFF + 1 wraps to 0, with no saturation and no flag.
  - When count_en = 0, counters hold.
- Counter write:
  - On wr_hit to a counter offset, that counter's enabled byte lanes load from mem_wdata at the next edge. Disabled lanes keep the old value.
  - A write and an event on the same counter in the same cycle: the written value wins and that cycle's event is dropped.
  - Other counters continue counting normally.
- CTRL write:
  - Lane 0 enabled: count_en <= mem_wdata[0].
  - mem_wdata[1] = 1 with lane 0 enabled: all counters <= 0 at the next edge, overriding same-cycle events.
  - Both bits apply in the same write: clear_all plus count_en = 0 leaves counters frozen at 0.
  - Lanes 1-3 are ignored.
- Handshake:
  - Writes always complete in one cycle.
  - wr_resp = 1 for exactly one cycle, in the cycle after each wr_hit.
  - Back-to-back wr_hit cycles give back-to-back wr_resp.
  - The MEM stage never stalls on this block.
- Outputs:
  - Counter outputs reflect register state directly, with no extra delay.
  - A load of a counter in the cycle after a write returns the written value.

Test Plan:
- Reset, then hold ev_branch high 5 cycles and ev_stall high 3 cycles -> branch = 5, stall_counter = 3, all other counters = 0, count_en = 1.
- Store 32'hFFFF_FFFE to BASE+0x14 with byte_enable 4'hF, then 3 cycles of ev_dcache_miss -> D_cache_miss = 1 after wrap; wr_resp pulses one cycle after the store.
- D_cache_hit = 32'h1234_5678; store 32'hAABB_CCDD to BASE+0x10 with byte_enable 4'b0011 -> D_cache_hit = 32'h1234_CCDD.
- Store 32'h0 to BASE+0x24, then 10 cycles of all events -> no counter changes. Store 32'h1 -> counting resumes on the next cycle.
- ev_mispredict high in the same cycle as a store of 32'h0000_0007 to BASE+0x04 -> mispredict = 7, not 8.
- Store 32'h3 to CTRL while all events are high and counters are nonzero -> all counters = 0 after the edge, then increment to 1 the following cycle. Store to BASE+0x28 or BASE+0x02 -> wr_hit = 0, no wr_resp, no state change.
